// File: rtl/debouncer_bank.sv
// Bank of independent debouncers: 2-flop synchroniser, saturating stability counter, edge pulses.
// Optional sticky per-channel event flags are built only when DEBOUNCER_BANK_EVENTS_EN is defined.
module debouncer_bank #(
  parameter int                  CHANNELS  = 8,
  parameter int                  CNT_WIDTH = 20,
  parameter logic [CHANNELS-1:0] RESET_VAL = {CHANNELS{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHANNELS-1:0]  in_signal,
  input  logic [CNT_WIDTH-1:0] threshold,
  output logic [CHANNELS-1:0]  out_signal,
  output logic [CHANNELS-1:0]  rise_pulse,
  output logic [CHANNELS-1:0]  fall_pulse,
  output logic                 any_change,
  output logic [CHANNELS-1:0]  events,
  input  logic [CHANNELS-1:0]  events_clr
);

  // Threshold of 0 behaves as 1, so the flip limit is never below zero.
  logic [CNT_WIDTH-1:0] thr_m1;
  assign thr_m1 = (threshold == '0) ? '0 : threshold - {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CHANNELS-1:0] flip;
  logic                any_change_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : gen_ch
      logic                 meta_reg;
      logic                 sync_reg;
      logic                 out_reg;
      logic                 rise_reg;
      logic                 fall_reg;
      logic [CNT_WIDTH-1:0] cnt_reg;
      logic                 differ;

      assign differ   = sync_reg ^ out_reg;
      assign flip[gi] = differ && (cnt_reg >= thr_m1);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          meta_reg <= RESET_VAL[gi];
          sync_reg <= RESET_VAL[gi];
          out_reg  <= RESET_VAL[gi];
          cnt_reg  <= '0;
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
        end else begin
          meta_reg <= in_signal[gi];
          sync_reg <= meta_reg;
          rise_reg <= flip[gi] & ~out_reg;
          fall_reg <= flip[gi] & out_reg;
          if (flip[gi]) begin
            out_reg <= ~out_reg;
            cnt_reg <= '0;
          end else if (!differ) begin
            cnt_reg <= '0;
          end else if (cnt_reg != '1) begin
            cnt_reg <= cnt_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end
        end
      end

      assign out_signal[gi] = out_reg;
      assign rise_pulse[gi] = rise_reg;
      assign fall_pulse[gi] = fall_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_change_reg <= 1'b0;
    else     any_change_reg <= |flip;
  end
  assign any_change = any_change_reg;

`ifdef DEBOUNCER_BANK_EVENTS_EN
  logic [CHANNELS-1:0] events_reg;

  // A new pulse takes priority over a clear strobe in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) events_reg <= '0;
    else     events_reg <= (events_reg & ~events_clr) | rise_pulse | fall_pulse;
  end
  assign events = events_reg;
`else
  logic unused_events_clr;
  assign unused_events_clr = ^events_clr;
  assign events = '0;
`endif

endmodule

// File: tb/tb_debouncer_bank.sv
// Directed self-checking bench for debouncer_bank; events checks adapt to DEBOUNCER_BANK_EVENTS_EN.
module tb_debouncer_bank;

  localparam int CH = 4;
  localparam int CW = 8;
`ifdef DEBOUNCER_BANK_EVENTS_EN
  localparam bit EV_EN = 1'b1;
`else
  localparam bit EV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, rst_r;
  logic [CH-1:0] in_sig, in_r, ev_clr;
  logic [CW-1:0] thr;
  logic [CH-1:0] out_sig, rise, fall, ev;
  logic [CH-1:0] out_r, rise_r, fall_r, ev_r;
  logic          any_chg, any_chg_r;

  int n_checks = 0;
  int n_fail   = 0;

  debouncer_bank #(.CHANNELS(CH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_signal(in_sig), .threshold(thr),
    .out_signal(out_sig), .rise_pulse(rise), .fall_pulse(fall),
    .any_change(any_chg), .events(ev), .events_clr(ev_clr)
  );

  debouncer_bank #(.CHANNELS(CH), .CNT_WIDTH(CW), .RESET_VAL(4'b0010)) dut_r (
    .clk(clk), .rst(rst_r), .in_signal(in_r), .threshold(thr),
    .out_signal(out_r), .rise_pulse(rise_r), .fall_pulse(fall_r),
    .any_change(any_chg_r), .events(ev_r), .events_clr(4'b0000)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    logic [CH-1:0] exp_ev;
    exp_ev = 4'b0000;
    tick(3);
    n_checks++; if (out_sig !== 4'b0000) begin n_fail++; $display("FAIL reset_out got %b expected %b", out_sig, 4'b0000); end
    n_checks++; if ({rise, fall} !== 8'h00) begin n_fail++; $display("FAIL reset_pulses got %b expected %b", {rise, fall}, 8'h00); end
    n_checks++; if (any_chg !== 1'b0) begin n_fail++; $display("FAIL reset_any got %b expected 0", any_chg); end
    n_checks++; if (ev !== exp_ev) begin n_fail++; $display("FAIL reset_events got %b expected %b", ev, exp_ev); end
    n_checks++; if (out_r !== 4'b0010) begin n_fail++; $display("FAIL reset_val_out got %b expected %b", out_r, 4'b0010); end
    rst = 1'b0;
    tick(3);
    n_checks++; if ({out_sig, rise, fall, any_chg} !== 13'h0) begin n_fail++; $display("FAIL release_quiet got %h expected 0", {out_sig, rise, fall, any_chg}); end
    $display("test_reset done");
  endtask

  task automatic test_rise_latency;
    in_sig = 4'b0001;
    tick(6);
    n_checks++; if (out_sig !== 4'b0000) begin n_fail++; $display("FAIL rise_early got %b expected %b", out_sig, 4'b0000); end
    tick(1);
    n_checks++; if (out_sig !== 4'b0001) begin n_fail++; $display("FAIL rise_at7 got %b expected %b", out_sig, 4'b0001); end
    n_checks++; if (rise !== 4'b0001 || fall !== 4'b0000) begin n_fail++; $display("FAIL rise_pulse got r=%b f=%b expected r=0001 f=0000", rise, fall); end
    n_checks++; if (any_chg !== 1'b1) begin n_fail++; $display("FAIL rise_any got %b expected 1", any_chg); end
    tick(1);
    n_checks++; if ({rise, any_chg} !== 5'b0) begin n_fail++; $display("FAIL rise_one_cycle got %b expected 0", {rise, any_chg}); end
    $display("test_rise_latency done");
  endtask

  task automatic test_glitch;
    logic [CH-1:0] seen;
    seen = '0;
    in_sig = 4'b0011;
    tick(4);
    in_sig = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen = seen | rise | fall | {4{any_chg}};
    end
    n_checks++; if (out_sig !== 4'b0001) begin n_fail++; $display("FAIL glitch_out got %b expected %b", out_sig, 4'b0001); end
    n_checks++; if (seen !== 4'b0000) begin n_fail++; $display("FAIL glitch_pulses got %b expected %b", seen, 4'b0000); end
    in_sig = 4'b0011;
    tick(6);
    n_checks++; if (out_sig !== 4'b0001) begin n_fail++; $display("FAIL glitch_count_cleared got %b expected %b", out_sig, 4'b0001); end
    tick(1);
    n_checks++; if (out_sig !== 4'b0011 || rise !== 4'b0010) begin n_fail++; $display("FAIL glitch_then_step got out=%b rise=%b expected out=0011 rise=0010", out_sig, rise); end
    $display("test_glitch done");
  endtask

  task automatic test_threshold;
    thr = 8'd0;
    in_sig = 4'b0111;
    tick(2);
    n_checks++; if (out_sig[2] !== 1'b0) begin n_fail++; $display("FAIL thr0_early got %b expected 0", out_sig[2]); end
    tick(1);
    n_checks++; if (out_sig[2] !== 1'b1 || rise[2] !== 1'b1) begin n_fail++; $display("FAIL thr0_at3 got out=%b rise=%b expected 1 1", out_sig[2], rise[2]); end
    thr = 8'd1;
    tick(2);
    in_sig = 4'b0011;
    tick(2);
    n_checks++; if (out_sig[2] !== 1'b1) begin n_fail++; $display("FAIL thr1_early got %b expected 1", out_sig[2]); end
    tick(1);
    n_checks++; if (out_sig[2] !== 1'b0 || fall[2] !== 1'b1) begin n_fail++; $display("FAIL thr1_at3 got out=%b fall=%b expected 0 1", out_sig[2], fall[2]); end
    thr = 8'd10;
    tick(2);
    in_sig = 4'b0111;
    tick(6);
    n_checks++; if (out_sig[2] !== 1'b0) begin n_fail++; $display("FAIL thr_change_early got %b expected 0", out_sig[2]); end
    thr = 8'd3;
    tick(1);
    n_checks++; if (out_sig[2] !== 1'b1) begin n_fail++; $display("FAIL thr_change_flip got %b expected 1", out_sig[2]); end
    tick(2);
    $display("test_threshold done");
  endtask

  task automatic test_simultaneous;
    logic [CH-1:0] exp_ev;
    ev_clr = 4'b1111;
    tick(1);
    ev_clr = 4'b0000;
    in_sig = 4'b1110;
    tick(4);
    n_checks++; if ({rise, fall} !== 8'h00) begin n_fail++; $display("FAIL simul_early got %b expected 0", {rise, fall}); end
    tick(1);
    n_checks++; if (rise !== 4'b1000 || fall !== 4'b0001 || any_chg !== 1'b1) begin n_fail++; $display("FAIL simul_pulses got r=%b f=%b any=%b expected 1000 0001 1", rise, fall, any_chg); end
    n_checks++; if (out_sig !== 4'b1110) begin n_fail++; $display("FAIL simul_out got %b expected %b", out_sig, 4'b1110); end
    tick(1);
    exp_ev = EV_EN ? 4'b1001 : 4'b0000;
    n_checks++; if (ev !== exp_ev) begin n_fail++; $display("FAIL events_set got %b expected %b", ev, exp_ev); end
    in_sig = 4'b1111;
    tick(5);
    n_checks++; if (rise !== 4'b0001) begin n_fail++; $display("FAIL ch0_reedge got %b expected %b", rise, 4'b0001); end
    ev_clr = 4'b0001;
    tick(1);
    ev_clr = 4'b0000;
    n_checks++; if (ev !== exp_ev) begin n_fail++; $display("FAIL events_set_wins got %b expected %b", ev, exp_ev); end
    ev_clr = 4'b0001;
    tick(1);
    ev_clr = 4'b0000;
    exp_ev = EV_EN ? 4'b1000 : 4'b0000;
    n_checks++; if (ev !== exp_ev) begin n_fail++; $display("FAIL events_clear got %b expected %b", ev, exp_ev); end
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid_count;
    logic [CH-1:0] seen;
    seen = '0;
    thr = 8'd5;
    rst_r = 1'b0;
    tick(3);
    n_checks++; if (out_r !== 4'b0010 || {rise_r, fall_r} !== 8'h00) begin n_fail++; $display("FAIL rv_release got out=%b pulses=%b expected 0010 0", out_r, {rise_r, fall_r}); end
    in_r = 4'b0000;
    tick(7);
    n_checks++; if (out_r !== 4'b0000 || fall_r !== 4'b0010) begin n_fail++; $display("FAIL rv_fall got out=%b fall=%b expected 0000 0010", out_r, fall_r); end
    in_r = 4'b0001;
    tick(5);
    #2 rst_r = 1'b1;
    #1;
    n_checks++; if (out_r !== 4'b0010) begin n_fail++; $display("FAIL rv_async_reset got %b expected %b", out_r, 4'b0010); end
    n_checks++; if ({rise_r, fall_r, any_chg_r} !== 9'h0) begin n_fail++; $display("FAIL rv_reset_pulses got %b expected 0", {rise_r, fall_r, any_chg_r}); end
    in_r = 4'b0010;
    tick(2);
    rst_r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      seen = seen | rise_r | fall_r | {4{any_chg_r}};
    end
    n_checks++; if (seen !== 4'b0000) begin n_fail++; $display("FAIL rv_no_release_pulse got %b expected %b", seen, 4'b0000); end
    in_r = 4'b0011;
    tick(6);
    n_checks++; if (out_r !== 4'b0010) begin n_fail++; $display("FAIL rv_fresh_early got %b expected %b", out_r, 4'b0010); end
    tick(1);
    n_checks++; if (out_r !== 4'b0011 || rise_r !== 4'b0001) begin n_fail++; $display("FAIL rv_fresh_at7 got out=%b rise=%b expected 0011 0001", out_r, rise_r); end
    $display("test_reset_mid_count done");
  endtask

  initial begin
    rst    = 1'b1;
    rst_r  = 1'b1;
    in_sig = 4'b0000;
    in_r   = 4'b0010;
    ev_clr = 4'b0000;
    thr    = 8'd5;
    test_reset();
    test_rise_latency();
    test_glitch();
    test_threshold();
    test_simultaneous();
    test_reset_mid_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debouncer_bank.md
DEBOUNCER_BANK -- requirements
Module: debouncer_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 8: number of independent debounce channels, range 1..32.
REQ-002 SHALL have parameter CNT_WIDTH, default 20: width of each stability counter and of the threshold input, range 2..24.
REQ-003 SHALL have parameter RESET_VAL, default {CHANNELS{1'b0}}: per-channel reset level of the synchroniser and of out_signal.
REQ-004 SHALL have port clk, input, 1: single system clock (16 MHz nominal); all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port in_signal, input, CHANNELS: raw, asynchronous, bouncing inputs.
REQ-007 SHALL have port threshold, input, CNT_WIDTH: required consecutive stable cycles, shared by all channels, quasi-static.
REQ-008 SHALL have port out_signal, output, CHANNELS: debounced levels, registered.
REQ-009 SHALL have port rise_pulse, output, CHANNELS: one-cycle pulse on each 0->1 transition of out_signal.
REQ-010 SHALL have port fall_pulse, output, CHANNELS: one-cycle pulse on each 1->0 transition of out_signal.
REQ-011 SHALL have port any_change, output, 1: OR of rise_pulse and fall_pulse, registered with them.
REQ-012 SHALL have port events, output, CHANNELS: sticky per-channel change flags.
REQ-013 SHALL have port events_clr, input, CHANNELS: write-one-to-clear strobes for events.

Function
REQ-014 Each channel SHALL pass in_signal through a 2-flop synchroniser; only the second flop (sync) feeds the debounce logic.
REQ-015 Each channel SHALL hold a CNT_WIDTH-bit counter: cleared when sync equals out_signal, otherwise incremented by 1.
REQ-016 When sync differs from out_signal and counter >= eff_thr-1 (eff_thr = threshold, with 0 treated as 1), the channel SHALL invert out_signal on that edge and clear the counter.
REQ-017 Latency SHALL be exactly 2+eff_thr cycles from the first clk edge sampling a new stable level to out_signal changing.
REQ-018 Any glitch returning sync to the out_signal level before the threshold is reached SHALL clear the counter with no output change.
REQ-019 The counter SHALL saturate at all-ones and never wrap to zero.
REQ-020 rise_pulse/fall_pulse SHALL assert in the same cycle out_signal takes its new value, for exactly one cycle.
REQ-021 A threshold change mid-count SHALL apply from the next edge using the current counter value (immediate flip if counter >= new eff_thr-1).
REQ-022 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL all be reported in the same cycle.

Reset
REQ-023 While rst is high: synchroniser flops and out_signal = RESET_VAL, counters = 0, rise_pulse = fall_pulse = 0, any_change = 0, events = 0.
REQ-024 Reset asserted mid-count SHALL discard the count; no pulse SHALL be generated on reset assertion or release.

Configuration
REQ-025 With macro DEBOUNCER_BANK_EVENTS_EN defined: events[ch] SHALL set on rise_pulse[ch] or fall_pulse[ch] and clear on events_clr[ch]; set SHALL win over a simultaneous clear.
REQ-026 Without DEBOUNCER_BANK_EVENTS_EN: events SHALL be tied to 0, events_clr SHALL be ignored, and no event flops SHALL be inferred; all other behaviour is unchanged.

Verification
REQ-027 CHANNELS=4, threshold=5, in_signal[0] 0->1 held: out_signal[0] rises exactly 7 cycles later; rise_pulse[0] high 1 cycle; any_change high that cycle.
REQ-028 threshold=5, in_signal[1] high for 4 cycles then low: out_signal[1] stays 0, no pulses, counter back to 0.
REQ-029 threshold=0 vs 1: both give out_signal change 3 cycles after input step.
REQ-030 Channels 0 and 3 change together with threshold=3: both pulses in the same cycle; events=4'b1001 (macro on); events_clr=4'b0001 with a new ch0 edge on the same cycle leaves events[0]=1.
REQ-031 rst asserted at count 3 of 5 with RESET_VAL=4'b0010: out_signal=4'b0010 immediately (asynchronous), no pulses after release, fresh 2+5 cycle latency thereafter.
